// File: rtl/reduction_mux_sched.sv
// Pair scheduler for the sparse reduction mux: walks a nonzero mask two set bits per beat.
// Optional perf counters (perf_beats, perf_stalls) are built when REDUCTION_MUX_SCHED_PERF_EN is defined.
module reduction_mux_sched #(
  parameter int NUM_IN = 4,
  parameter int SEL_IN = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mask_valid,
  output logic                  mask_ready,
  input  logic [NUM_IN-1:0]     mask,
  output logic                  sel_valid,
  input  logic                  sel_ready,
  output logic [2*SEL_IN-1:0]   sel,
  output logic [1:0]            pair_vld,
  output logic                  sel_last
`ifdef REDUCTION_MUX_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_beats,
  output logic [31:0]           perf_stalls
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [NUM_IN-1:0] ONE = NUM_IN'(1);

  state_t              state_reg, state_next;
  logic [NUM_IN-1:0]   residual_reg, residual_next;
  logic [NUM_IN-1:0]   issued_reg, issued_next;
  logic                sel_valid_reg, sel_valid_next;
  logic [2*SEL_IN-1:0] sel_reg, sel_next;
  logic [1:0]          pair_vld_reg, pair_vld_next;
  logic                sel_last_reg, sel_last_next;

  logic [NUM_IN-1:0]   src;
  logic [NUM_IN-1:0]   low1, rest1, low2, rest2;
  logic [SEL_IN-1:0]   right_idx, left_idx;
  logic                fire;

  // The pair to present next comes from the incoming mask in IDLE, or from
  // whatever is left once the currently presented pair has been issued.
  assign src   = (state_reg == IDLE) ? mask : (residual_reg & ~issued_reg);
  assign low1  = src & (~src + ONE);
  assign rest1 = src & ~low1;
  assign low2  = rest1 & (~rest1 + ONE);
  assign rest2 = rest1 & ~low2;
  assign fire  = sel_valid_reg & sel_ready;

  genvar gi;
  generate
    for (gi = 0; gi < SEL_IN; gi++) begin : g_enc
      logic [NUM_IN-1:0] pos_mask;
      always_comb begin
        pos_mask = '0;
        for (int i = 0; i < NUM_IN; i++) begin
          pos_mask[i] = ((i >> gi) & 1) != 0;
        end
      end
      // One-hot to binary: index bit gi is set when the hot position has bit gi set.
      assign right_idx[gi] = |(low1 & pos_mask);
      assign left_idx[gi]  = |(low2 & pos_mask);
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    residual_next  = residual_reg;
    issued_next    = issued_reg;
    sel_valid_next = sel_valid_reg;
    sel_next       = sel_reg;
    pair_vld_next  = pair_vld_reg;
    sel_last_next  = sel_last_reg;
    mask_ready     = 1'b0;

    case (state_reg)
      IDLE: begin
        mask_ready = 1'b1;
        if (mask_valid) begin
          state_next     = RUN;
          residual_next  = mask;
          issued_next    = low1 | low2;
          sel_valid_next = 1'b1;
          sel_next       = {left_idx, right_idx};
          pair_vld_next  = {|low2, |low1};
          sel_last_next  = (rest2 == '0);
        end
      end
      RUN: begin
        if (fire) begin
          if (sel_last_reg) begin
            state_next     = IDLE;
            residual_next  = '0;
            issued_next    = '0;
            sel_valid_next = 1'b0;
            sel_next       = '0;
            pair_vld_next  = 2'b00;
            sel_last_next  = 1'b0;
          end else begin
            residual_next  = src;
            issued_next    = low1 | low2;
            sel_next       = {left_idx, right_idx};
            pair_vld_next  = {|low2, |low1};
            sel_last_next  = (rest2 == '0);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      residual_reg  <= '0;
      issued_reg    <= '0;
      sel_valid_reg <= 1'b0;
      sel_reg       <= '0;
      pair_vld_reg  <= 2'b00;
      sel_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      residual_reg  <= residual_next;
      issued_reg    <= issued_next;
      sel_valid_reg <= sel_valid_next;
      sel_reg       <= sel_next;
      pair_vld_reg  <= pair_vld_next;
      sel_last_reg  <= sel_last_next;
    end
  end

  assign sel_valid = sel_valid_reg;
  assign sel       = sel_reg;
  assign pair_vld  = pair_vld_reg;
  assign sel_last  = sel_last_reg;

`ifdef REDUCTION_MUX_SCHED_PERF_EN
  logic [31:0] perf_beats_reg, perf_stalls_reg;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats_reg  <= '0;
      perf_stalls_reg <= '0;
    end else begin
      if (fire && !(&perf_beats_reg)) begin
        perf_beats_reg <= perf_beats_reg + 32'd1;
      end
      if (sel_valid_reg && !sel_ready && !(&perf_stalls_reg)) begin
        perf_stalls_reg <= perf_stalls_reg + 32'd1;
      end
    end
  end

  assign perf_beats  = perf_beats_reg;
  assign perf_stalls = perf_stalls_reg;
`endif

endmodule

// File: tb/tb_reduction_mux_sched.sv
// Randomized bench for reduction_mux_sched against a queue-of-beats reference model.
module tb_reduction_mux_sched;

  logic       clk;
  logic       rst_n;
  logic       mask_valid;
  logic       mask_ready;
  logic [3:0] mask;
  logic       sel_valid;
  logic       sel_ready;
  logic [3:0] sel;
  logic [1:0] pair_vld;
  logic       sel_last;
`ifdef REDUCTION_MUX_SCHED_PERF_EN
  logic [31:0] perf_beats;
  logic [31:0] perf_stalls;
`endif

  reduction_mux_sched #(.NUM_IN(4), .SEL_IN(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .mask       (mask),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel        (sel),
    .pair_vld   (pair_vld),
    .sel_last   (sel_last)
`ifdef REDUCTION_MUX_SCHED_PERF_EN
    ,
    .perf_beats (perf_beats),
    .perf_stalls(perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] left;
    logic [1:0] right;
    logic [1:0] pv;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  bit    busy;
  int    errors;
  int    checks;
  int    model_beats;
  int    model_stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats for one mask: list set-bit indices in ascending order, pair them up.
  task automatic build_beats(input logic [3:0] m);
    int    idx[$];
    beat_t b;
    for (int i = 0; i < 4; i++) if (m[i]) idx.push_back(i);
    if (idx.size() == 0) begin
      b = '{left: 2'd0, right: 2'd0, pv: 2'b00, last: 1'b1};
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < idx.size(); k += 2) begin
        b.right = 2'(idx[k]);
        if (k + 1 < idx.size()) begin
          b.left = 2'(idx[k+1]);
          b.pv   = 2'b11;
        end else begin
          b.left = 2'd0;
          b.pv   = 2'b01;
        end
        b.last = (k + 2 >= idx.size());
        exp_q.push_back(b);
      end
    end
  endtask

  // One cycle: check what the DUT shows now, then apply inputs for the next edge.
  task automatic step(input logic mv, input logic [3:0] m, input logic sr);
    @(negedge clk);
    check("mask_ready", {31'd0, mask_ready}, {31'd0, !busy});
    check("sel_valid", {31'd0, sel_valid}, {31'd0, busy});
    if (busy && exp_q.size() > 0) begin
      check("sel", {28'd0, sel}, {28'd0, exp_q[0].left, exp_q[0].right});
      check("pair_vld", {30'd0, pair_vld}, {30'd0, exp_q[0].pv});
      check("sel_last", {31'd0, sel_last}, {31'd0, exp_q[0].last});
    end
    mask_valid = mv;
    mask       = m;
    sel_ready  = sr;
    if (busy) begin
      if (sr) begin
        $display("beat sel={%0d,%0d} pair_vld=%b last=%b", exp_q[0].left, exp_q[0].right,
                 exp_q[0].pv, exp_q[0].last);
        model_beats++;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) busy = 1'b0;
      end else begin
        model_stalls++;
      end
    end else if (mv) begin
      build_beats(m);
      busy = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    mask_valid = 1'b0;
    sel_ready  = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("rst_sel_valid", {31'd0, sel_valid}, 32'd0);
    check("rst_mask_ready", {31'd0, mask_ready}, 32'd1);
    check("rst_sel", {28'd0, sel}, 32'd0);
    check("rst_pair_vld", {30'd0, pair_vld}, 32'd0);
    check("rst_sel_last", {31'd0, sel_last}, 32'd0);
`ifdef REDUCTION_MUX_SCHED_PERF_EN
    check("rst_perf_beats", perf_beats, 32'd0);
    check("rst_perf_stalls", perf_stalls, 32'd0);
`endif
    exp_q.delete();
    busy         = 1'b0;
    model_beats  = 0;
    model_stalls = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    busy       = 1'b0;
    rst_n      = 1'b0;
    mask_valid = 1'b0;
    mask       = 4'd0;
    sel_ready  = 1'b0;
    repeat (2) @(posedge clk);
    apply_reset();

    // mask 1011, always ready
    step(1'b1, 4'b1011, 1'b1);
    repeat (3) step(1'b0, 4'b0000, 1'b1);
    // empty mask
    step(1'b1, 4'b0000, 1'b1);
    repeat (2) step(1'b0, 4'b0000, 1'b1);
    // mask 1111 with 3 stall cycles, mask_valid held during RUN with 0101
    step(1'b1, 4'b1111, 1'b0);
    repeat (3) step(1'b1, 4'b0101, 1'b0);
    repeat (3) step(1'b1, 4'b0101, 1'b1);
    repeat (3) step(1'b0, 4'b0000, 1'b1);
    // reset after beat1 of 1111
    step(1'b1, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b0);
    apply_reset();
    repeat (3) step(1'b0, 4'b0000, 1'b1);

    for (int n = 0; n < 500; n++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (6) step(1'b0, 4'b0000, 1'b1);

`ifdef REDUCTION_MUX_SCHED_PERF_EN
    check("perf_beats_rand", perf_beats, 32'(model_beats));
    check("perf_stalls_rand", perf_stalls, 32'(model_stalls));
    apply_reset();
    step(1'b1, 4'b1011, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b0);
    check("perf_beats", perf_beats, 32'd3);
    check("perf_stalls", perf_stalls, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
